// File: rtl/top44_seq.sv
// Sequencer for a systolic-array pass: stream in_len words from the input SRAM,
// drain the array, then shift out_len results to the output SRAM.
// Optional macro TOP44_SEQ_PERF_CNT_EN adds the 16-bit run_cycles counter.
module top44_seq #(
    parameter int ADDR_W    = 10,
    parameter int DRAIN_CYC = 8
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] out_base,
    input  logic [ADDR_W-1:0] in_len,
    input  logic [ADDR_W-1:0] out_len,
    output logic              input_en_ramin,
    output logic              wr_in,
    output logic [ADDR_W-1:0] adder_in,
    output logic              input_en_sys,
    output logic              output_en_sys,
    output logic              input_en_ramout,
    output logic              wr_out,
    output logic [ADDR_W-1:0] adder_out,
    output logic              busy,
    output logic              done
`ifdef TOP44_SEQ_PERF_CNT_EN
    ,
    output logic [15:0]       run_cycles
`endif
);

    typedef enum logic [2:0] {IDLE, FEED, DRAIN, STORE, DONE} state_t;

    localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);
    localparam bit                NO_DRAIN   = (DRAIN_CYC < 1);
    localparam logic [15:0]       DRAIN_LAST = 16'(NO_DRAIN ? 0 : DRAIN_CYC - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [15:0]       drain_cnt;
    logic [ADDR_W-1:0] out_len_q;
    logic [ADDR_W-1:0] out_ptr;
    logic              start_acc;

    assign wr_in     = 1'b0;
    assign start_acc = (state == IDLE) && start && !abort;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state           <= IDLE;
            cnt             <= '0;
            drain_cnt       <= '0;
            out_len_q       <= '0;
            out_ptr         <= '0;
            input_en_ramin  <= 1'b0;
            adder_in        <= '0;
            input_en_sys    <= 1'b0;
            output_en_sys   <= 1'b0;
            input_en_ramout <= 1'b0;
            wr_out          <= 1'b0;
            adder_out       <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else if (abort && state != IDLE) begin
            // Addresses are deliberately left untouched so they hold across an abort.
            state           <= IDLE;
            input_en_ramin  <= 1'b0;
            input_en_sys    <= 1'b0;
            output_en_sys   <= 1'b0;
            input_en_ramout <= 1'b0;
            wr_out          <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            // Read data arrives one cycle after the SRAM strobe; accout is registered too.
            input_en_sys    <= input_en_ramin;
            input_en_ramout <= output_en_sys;
            wr_out          <= output_en_sys;
            done            <= 1'b0;
            if (output_en_sys) begin
                adder_out <= out_ptr;
                out_ptr   <= out_ptr + ONE;
            end
            case (state)
                IDLE: begin
                    if (start_acc) begin
                        out_ptr   <= out_base;
                        out_len_q <= out_len;
                        busy      <= 1'b1;
                        if (in_len == '0 || out_len == '0) begin
                            state <= DONE;
                        end else begin
                            state          <= FEED;
                            input_en_ramin <= 1'b1;
                            adder_in       <= in_base;
                            cnt            <= in_len - ONE;
                        end
                    end
                end
                FEED: begin
                    if (cnt == '0) begin
                        input_en_ramin <= 1'b0;
                        if (NO_DRAIN) begin
                            state         <= STORE;
                            output_en_sys <= 1'b1;
                            cnt           <= out_len_q - ONE;
                        end else begin
                            state     <= DRAIN;
                            drain_cnt <= DRAIN_LAST;
                        end
                    end else begin
                        adder_in <= adder_in + ONE;
                        cnt      <= cnt - ONE;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state         <= STORE;
                        output_en_sys <= 1'b1;
                        cnt           <= out_len_q - ONE;
                    end else begin
                        drain_cnt <= drain_cnt - 16'd1;
                    end
                end
                STORE: begin
                    if (cnt == '0) begin
                        output_en_sys <= 1'b0;
                        state         <= DONE;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TOP44_SEQ_PERF_CNT_EN
    // Survives abort and completion; only a new accepted start clears it.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            run_cycles <= '0;
        end else if (start_acc) begin
            run_cycles <= '0;
        end else if (busy && run_cycles != 16'hFFFF) begin
            run_cycles <= run_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_top44_seq.sv
// Randomized self-checking bench for top44_seq; expected outputs come from a
// cycle-window model derived from run lengths, not from the FSM structure.
module tb_top44_seq;

    localparam int D = 8;

    logic       clk = 1'b0;
    logic       rst_b = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [9:0] in_base = '0, out_base = '0, in_len = '0, out_len = '0;
    logic       input_en_ramin, wr_in, input_en_sys, output_en_sys;
    logic       input_en_ramout, wr_out, busy, done;
    logic [9:0] adder_in, adder_out;
    logic [27:0] got;

    int n_tests = 0;
    int n_fail  = 0;

    int         m_ib, m_il, m_ob, m_ol, m_abort_k;
    logic [9:0] m_prev_ain = '0, m_prev_aout = '0;

    always #5 clk = ~clk;

    top44_seq #(.ADDR_W(10), .DRAIN_CYC(D)) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .abort(abort),
        .in_base(in_base), .out_base(out_base), .in_len(in_len), .out_len(out_len),
        .input_en_ramin(input_en_ramin), .wr_in(wr_in), .adder_in(adder_in),
        .input_en_sys(input_en_sys), .output_en_sys(output_en_sys),
        .input_en_ramout(input_en_ramout), .wr_out(wr_out), .adder_out(adder_out),
        .busy(busy), .done(done)
    );

    assign got = {input_en_ramin, wr_in, adder_in, input_en_sys, output_en_sys,
                  input_en_ramout, wr_out, adder_out, busy, done};

    // Expected output vector in cycle k after the start edge (k=1 is the first cycle).
    function automatic logic [27:0] model_vec(int k);
        int kk, last_k, idx;
        bit run, live;
        logic [9:0] ain, aout;
        logic [27:0] v;
        run    = (m_il != 0) && (m_ol != 0);
        last_k = run ? m_il + D + m_ol + 2 : 2;
        live   = (m_abort_k == 0) || (k <= m_abort_k);
        kk     = live ? k : m_abort_k;
        ain    = m_prev_ain;
        aout   = m_prev_aout;
        if (run && kk >= 1)
            ain = 10'(m_ib + ((kk < m_il) ? kk : m_il) - 1);
        if (run && kk >= m_il + D + 2) begin
            idx  = kk - m_il - D - 1;
            aout = 10'(m_ob + ((idx < m_ol) ? idx : m_ol) - 1);
        end
        v = '0;
        v[25:16] = ain;
        v[11:2]  = aout;
        if (live) begin
            v[27] = run && k >= 1 && k <= m_il;
            v[15] = run && k >= 2 && k <= m_il + 1;
            v[14] = run && k >= m_il + D + 1 && k <= m_il + D + m_ol;
            v[13] = run && k >= m_il + D + 2 && k <= m_il + D + m_ol + 1;
            v[12] = v[13];
            v[1]  = k >= 1 && k < last_k;
            v[0]  = k == last_k;
        end
        return v;
    endfunction

    function automatic int run_len();
        return ((m_il != 0) && (m_ol != 0)) ? m_il + D + m_ol + 2 : 2;
    endfunction

    task automatic launch(input int ib, input int il, input int ob, input int ol);
        m_ib = ib; m_il = il; m_ob = ob; m_ol = ol; m_abort_k = 0;
        @(posedge clk); #1;
        in_base = 10'(ib); in_len = 10'(il); out_base = 10'(ob); out_len = 10'(ol);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic retire();
        logic [27:0] v;
        v = model_vec(100000);
        m_prev_ain  = v[25:16];
        m_prev_aout = v[11:2];
    endtask

    task automatic test_reset();
        #1 rst_b = 1'b0;
        #1;
        n_tests++;
        if (got !== 28'h0) begin
            n_fail++; $display("FAIL reset_async got=%h exp=%h", got, 28'h0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (got !== 28'h0) begin
            n_fail++; $display("FAIL reset_held got=%h exp=%h", got, 28'h0);
        end
        rst_b = 1'b1;
        @(negedge clk);
        n_tests++;
        if (got !== 28'h0) begin
            n_fail++; $display("FAIL reset_idle got=%h exp=%h", got, 28'h0);
        end
    endtask

    task automatic test_basic();
        launch(0, 4, 16, 4);
        for (int k = 1; k <= run_len() + 2; k++) begin
            @(negedge clk);
            n_tests++;
            if (got !== model_vec(k)) begin
                n_fail++; $display("FAIL basic k=%0d got=%h exp=%h", k, got, model_vec(k));
            end
        end
        retire();
    endtask

    task automatic test_wrap();
        launch(1022, 4, 1021, 5);
        for (int k = 1; k <= run_len() + 2; k++) begin
            @(negedge clk);
            n_tests++;
            if (got !== model_vec(k)) begin
                n_fail++; $display("FAIL wrap k=%0d got=%h exp=%h", k, got, model_vec(k));
            end
        end
        retire();
    endtask

    task automatic test_zero_len();
        for (int c = 0; c < 2; c++) begin
            if (c == 0) launch(3, 0, 7, 5);
            else        launch(3, 5, 7, 0);
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                n_tests++;
                if (got !== model_vec(k)) begin
                    n_fail++; $display("FAIL zero_len c=%0d k=%0d got=%h exp=%h", c, k, got, model_vec(k));
                end
            end
            retire();
        end
    endtask

    task automatic test_abort();
        int ak;
        launch(10, 3, 100, 3);
        ak = 3 + 3;
        for (int k = 1; k <= run_len() + 2; k++) begin
            @(negedge clk);
            n_tests++;
            if (got !== model_vec(k)) begin
                n_fail++; $display("FAIL abort k=%0d got=%h exp=%h", k, got, model_vec(k));
            end
            abort = (k == ak);
            if (k == ak) m_abort_k = ak;
        end
        abort = 1'b0;
        retire();
    endtask

    task automatic test_async_reset();
        int rk;
        launch(50, 2, 200, 5);
        rk = 2 + D + 2;
        for (int k = 1; k <= rk; k++) begin
            @(negedge clk);
            n_tests++;
            if (got !== model_vec(k)) begin
                n_fail++; $display("FAIL pre_reset k=%0d got=%h exp=%h", k, got, model_vec(k));
            end
        end
        #2 rst_b = 1'b0;
        #1;
        n_tests++;
        if (got !== 28'h0) begin
            n_fail++; $display("FAIL midstore_reset got=%h exp=%h", got, 28'h0);
        end
        @(posedge clk); #2 rst_b = 1'b1;
        m_prev_ain = '0; m_prev_aout = '0;
        launch(60, 3, 300, 3);
        for (int k = 1; k <= run_len() + 2; k++) begin
            @(negedge clk);
            n_tests++;
            if (got !== model_vec(k)) begin
                n_fail++; $display("FAIL post_reset k=%0d got=%h exp=%h", k, got, model_vec(k));
            end
        end
        retire();
    endtask

    task automatic test_start_during_feed();
        launch(5, 6, 40, 2);
        for (int k = 1; k <= run_len() + 2; k++) begin
            @(negedge clk);
            n_tests++;
            if (got !== model_vec(k)) begin
                n_fail++; $display("FAIL busy_start k=%0d got=%h exp=%h", k, got, model_vec(k));
            end
            if (k == 2) begin
                start = 1'b1; in_len = 10'd2; in_base = 10'd900; out_len = 10'd1; out_base = 10'd7;
            end else begin
                start = 1'b0;
            end
        end
        retire();
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            launch(int'($urandom_range(1023)), int'($urandom_range(6, 1)),
                   int'($urandom_range(1023)), int'($urandom_range(6, 1)));
            for (int k = 1; k <= run_len() + 2; k++) begin
                @(negedge clk);
                n_tests++;
                if (got !== model_vec(k)) begin
                    n_fail++; $display("FAIL random r=%0d k=%0d got=%h exp=%h", r, k, got, model_vec(k));
                end
            end
            retire();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_zero_len();
        test_abort();
        test_async_reset();
        test_start_during_feed();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
